// File: rtl/uart_cmd_slave_if.sv
// Byte-stream and register-bus signal bundle between a UART command slave and its surroundings.
// The slave modport is the command decoder; the master modport is the UART/bus environment.
interface uart_cmd_slave_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_en;
    logic                  tx_done;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_overrun;

    modport slave (
        input  rx_data, rx_done, tx_done, bus_ack, bus_rdata,
        output tx_data, tx_en, bus_addr, bus_wdata, bus_wr, bus_rd,
               busy, err_timeout, err_overrun
    );

    modport master (
        output rx_data, rx_done, tx_done, bus_ack, bus_rdata,
        input  tx_data, tx_en, bus_addr, bus_wdata, bus_wr, bus_rd,
               busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes {rw, addr} header packets into register-bus reads/writes
// and returns one reply byte per read, with per-phase timeout and overrun reporting.
module uart_cmd_slave #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_slave_if.slave  bif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        BUS_WR   = 3'd2,
        BUS_RD   = 3'd3,
        SEND     = 3'd4,
        WAIT_TX  = 3'd5
    } state_t;

    state_t                state_q;
    logic [31:0]           cnt_q;
    logic                  armed_q;
    logic                  rx_done_q, rx_prev_q, rx_evt_q;
    logic                  tx_done_q, tx_prev_q, tx_evt_q;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_byte_q;
    logic [DATA_WIDTH-1:0] tx_data_q, bus_wdata_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic                  tx_en_q, bus_wr_q, bus_rd_q, busy_q;
    logic                  err_timeout_q, err_overrun_q;

    logic                  rx_prev_d, tx_prev_d;
    logic                  rx_evt_d, tx_evt_d;
    logic                  timeout_s;

    assign timeout_s = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Edge-detect next state; the first cycle after reset seeds the history so a held level is not an edge.
    always_comb begin
        rx_prev_d = bif.rx_done;
        tx_prev_d = bif.tx_done;
        if (armed_q) begin
            rx_prev_d = rx_done_q;
            tx_prev_d = tx_done_q;
        end else begin
            rx_prev_d = bif.rx_done;
            tx_prev_d = bif.tx_done;
        end
        rx_evt_d = rx_done_q & ~rx_prev_q;
        tx_evt_d = tx_done_q & ~tx_prev_q;
    end

    // Input registers and one-cycle rx/tx events, with the received byte carried alongside its event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q   <= 1'b0;
            rx_done_q <= 1'b0;
            rx_prev_q <= 1'b0;
            rx_evt_q  <= 1'b0;
            tx_done_q <= 1'b0;
            tx_prev_q <= 1'b0;
            tx_evt_q  <= 1'b0;
            rx_data_q <= '0;
            rx_byte_q <= '0;
        end else begin
            armed_q   <= 1'b1;
            rx_done_q <= bif.rx_done;
            rx_prev_q <= rx_prev_d;
            rx_evt_q  <= rx_evt_d;
            tx_done_q <= bif.tx_done;
            tx_prev_q <= tx_prev_d;
            tx_evt_q  <= tx_evt_d;
            rx_data_q <= bif.rx_data;
            rx_byte_q <= rx_data_q;
        end
    end

    // Transaction FSM with registered outputs; expected events take priority over the phase timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            tx_data_q     <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            tx_en_q       <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            tx_en_q       <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 32'd0;
                    if (rx_evt_q) begin
                        bus_addr_q <= rx_byte_q[ADDR_WIDTH-1:0];
                        busy_q     <= 1'b1;
                        if (rx_byte_q[DATA_WIDTH-1]) begin
                            state_q <= GET_DATA;
                        end else begin
                            state_q  <= BUS_RD;
                            bus_rd_q <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                GET_DATA: begin
                    if (rx_evt_q) begin
                        bus_wdata_q <= rx_byte_q;
                        bus_wr_q    <= 1'b1;
                        state_q     <= BUS_WR;
                        cnt_q       <= 32'd0;
                    end else if (timeout_s) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        cnt_q         <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                BUS_WR: begin
                    err_overrun_q <= rx_evt_q;
                    if (bif.bus_ack) begin
                        state_q  <= IDLE;
                        bus_wr_q <= 1'b0;
                        busy_q   <= 1'b0;
                        cnt_q    <= 32'd0;
                    end else if (timeout_s) begin
                        state_q       <= IDLE;
                        bus_wr_q      <= 1'b0;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        cnt_q         <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                BUS_RD: begin
                    err_overrun_q <= rx_evt_q;
                    if (bif.bus_ack) begin
                        tx_data_q <= bif.bus_rdata;
                        bus_rd_q  <= 1'b0;
                        tx_en_q   <= 1'b1;
                        state_q   <= SEND;
                        cnt_q     <= 32'd0;
                    end else if (timeout_s) begin
                        state_q       <= IDLE;
                        bus_rd_q      <= 1'b0;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        cnt_q         <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                SEND: begin
                    err_overrun_q <= rx_evt_q;
                    state_q       <= WAIT_TX;
                    cnt_q         <= 32'd0;
                end
                WAIT_TX: begin
                    err_overrun_q <= rx_evt_q;
                    if (tx_evt_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 32'd0;
                    end else if (timeout_s) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        cnt_q         <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= 32'd0;
                    bus_wr_q <= 1'b0;
                    bus_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bif.tx_data     = tx_data_q;
    assign bif.tx_en       = tx_en_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.bus_wdata   = bus_wdata_q;
    assign bif.bus_wr      = bus_wr_q;
    assign bif.bus_rd      = bus_rd_q;
    assign bif.busy        = busy_q;
    assign bif.err_timeout = err_timeout_q;
    assign bif.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: directed packet scenarios plus randomized packets checked
// against expectations derived from the packet format and latency rules.
module tb_uart_cmd_slave;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_slave_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) bif ();

    uart_cmd_slave #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(7),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bif  (bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txen_cnt, tout_cnt, ovr_cnt, wr_rise, rd_rise;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse and rising-edge counters observed away from the active edge.
    always @(negedge clk) begin
        if (bif.tx_en === 1'b1) txen_cnt++;
        if (bif.err_timeout === 1'b1) tout_cnt++;
        if (bif.err_overrun === 1'b1) ovr_cnt++;
        if (bif.bus_wr === 1'b1 && wr_prev !== 1'b1) wr_rise++;
        if (bif.bus_rd === 1'b1 && rd_prev !== 1'b1) rd_rise++;
        wr_prev = bif.bus_wr;
        rd_prev = bif.bus_rd;
    end

    task automatic clear_mon();
        txen_cnt = 0; tout_cnt = 0; ovr_cnt = 0; wr_rise = 0; rd_rise = 0;
    endtask

    // t0 is the edge index at which rx_done is first sampled high.
    task automatic send_byte(input logic [7:0] b, input int hold, output int t0);
        @(posedge clk); #1;
        bif.rx_data = b;
        bif.rx_done = 1'b1;
        t0 = cyc + 1;
        repeat (hold) @(posedge clk);
        #1 bif.rx_done = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] hdr, input logic [7:0] data, input int ack_delay);
        int t0, t1, n;
        logic [6:0] exp_addr;
        exp_addr = 7'(hdr % 8'd128);
        @(posedge clk); #1 clear_mon();
        send_byte(hdr, 1, t0);
        repeat (2) @(posedge clk);
        send_byte(data, 1, t1);
        n = 0;
        while (bif.bus_wr !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bif.bus_wr !== 1'b1) begin
            errors++; $display("FAIL wr_wait: bus_wr=%b required 1", bif.bus_wr);
        end else if (cyc - t1 != 2) begin
            errors++; $display("FAIL wr_latency: %0d edges required 2", cyc - t1);
        end
        checks++;
        if (bif.bus_addr !== exp_addr || bif.bus_wdata !== data) begin
            errors++;
            $display("FAIL wr_addr_data: got %h/%h required %h/%h", bif.bus_addr, bif.bus_wdata, exp_addr, data);
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            checks++;
            if (bif.bus_wr !== 1'b1) begin
                errors++; $display("FAIL wr_hold: bus_wr=%b required 1", bif.bus_wr);
            end
        end
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 8'($urandom);
        @(posedge clk); #1 bif.bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.bus_wr !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL wr_done: bus_wr=%b busy=%b required 0/0", bif.bus_wr, bif.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (txen_cnt != 0 || wr_rise != 1 || tout_cnt != 0) begin
            errors++;
            $display("FAIL wr_counts: tx_en=%0d wr_rise=%0d tout=%0d required 0/1/0", txen_cnt, wr_rise, tout_cnt);
        end
    endtask

    task automatic do_read(input logic [7:0] hdr, input logic [7:0] rdata, input int ack_delay,
                           input int hold, input bit overrun);
        int t0, t1, n;
        logic [6:0] exp_addr;
        exp_addr = 7'(hdr % 8'd128);
        @(posedge clk); #1 clear_mon();
        send_byte(hdr, hold, t0);
        n = 0;
        while (bif.bus_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bif.bus_rd !== 1'b1) begin
            errors++; $display("FAIL rd_wait: bus_rd=%b required 1", bif.bus_rd);
        end else if (hold == 1 && cyc - t0 != 2) begin
            errors++; $display("FAIL rd_latency: %0d edges required 2", cyc - t0);
        end
        checks++;
        if (bif.bus_addr !== exp_addr) begin
            errors++; $display("FAIL rd_addr: got %h required %h", bif.bus_addr, exp_addr);
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            checks++;
            if (bif.bus_rd !== 1'b1 || bif.tx_en !== 1'b0) begin
                errors++; $display("FAIL rd_hold: bus_rd=%b tx_en=%b required 1/0", bif.bus_rd, bif.tx_en);
            end
        end
        bif.bus_ack = 1'b1;
        bif.bus_rdata = rdata;
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        bif.bus_rdata = ~rdata;
        @(negedge clk);
        checks++;
        if (bif.tx_en !== 1'b1 || bif.tx_data !== rdata || bif.bus_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_send: tx_en=%b tx_data=%h bus_rd=%b required 1/%h/0", bif.tx_en, bif.tx_data, bif.bus_rd, rdata);
        end
        @(negedge clk);
        checks++;
        if (bif.tx_en !== 1'b0 || bif.tx_data !== rdata) begin
            errors++; $display("FAIL rd_send_len: tx_en=%b tx_data=%h required 0/%h", bif.tx_en, bif.tx_data, rdata);
        end
        if (overrun) begin
            send_byte(8'h40, 1, t1);
            repeat (4) @(posedge clk); #1;
            checks++;
            if (ovr_cnt != 1 || bif.tx_data !== rdata || bif.busy !== 1'b1) begin
                errors++;
                $display("FAIL overrun: ovr=%0d tx_data=%h busy=%b required 1/%h/1", ovr_cnt, bif.tx_data, bif.busy, rdata);
            end
        end
        @(posedge clk); #1 bif.tx_done = 1'b1;
        n = 0;
        while (bif.busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bif.busy !== 1'b0 || bif.tx_data !== rdata) begin
            errors++; $display("FAIL rd_done: busy=%b tx_data=%h required 0/%h", bif.busy, bif.tx_data, rdata);
        end
        @(posedge clk); #1 bif.tx_done = 1'b0;
        checks++;
        if (txen_cnt != 1 || rd_rise != 1 || tout_cnt != 0) begin
            errors++;
            $display("FAIL rd_counts: tx_en=%0d rd_rise=%0d tout=%0d required 1/1/0", txen_cnt, rd_rise, tout_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bif.rx_data = 8'h00; bif.rx_done = 1'b0; bif.tx_done = 1'b0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({bif.tx_en, bif.bus_wr, bif.bus_rd, bif.busy, bif.err_timeout, bif.err_overrun,
             bif.tx_data, bif.bus_addr, bif.bus_wdata} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: tx_en=%b wr=%b rd=%b busy=%b data=%h addr=%h wdata=%h required all 0",
                     bif.tx_en, bif.bus_wr, bif.bus_rd, bif.busy, bif.tx_data, bif.bus_addr, bif.bus_wdata);
        end
        bif.rx_data = 8'h12;
        bif.rx_done = 1'b1;
        @(negedge clk);
        clear_mon();
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (bif.busy !== 1'b0 || rd_rise != 0) begin
            errors++; $display("FAIL reset_held_rx: busy=%b rd_rise=%0d required 0/0", bif.busy, rd_rise);
        end
        bif.rx_done = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_rx_fall: busy=%b required 0", bif.busy);
        end
    endtask

    task automatic test_stray();
        @(posedge clk); #1 clear_mon();
        bif.bus_ack = 1'b1; bif.tx_done = 1'b1;
        @(posedge clk); #1 bif.bus_ack = 1'b0; bif.tx_done = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (bif.busy !== 1'b0 || txen_cnt != 0 || wr_rise != 0 || rd_rise != 0) begin
            errors++; $display("FAIL stray_ack: busy=%b tx_en=%0d required 0/0", bif.busy, txen_cnt);
        end
    endtask

    task automatic test_timeout();
        int t0, n;
        @(posedge clk); #1 clear_mon();
        send_byte(8'h85, 1, t0);
        n = 0;
        while (bif.err_timeout !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (bif.err_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_wait: err_timeout=%b required 1", bif.err_timeout);
        end else if (cyc - t0 != 102) begin
            errors++; $display("FAIL timeout_time: %0d edges required 102", cyc - t0);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_rise != 0 || bif.busy !== 1'b0 || tout_cnt != 1 || txen_cnt != 0) begin
            errors++;
            $display("FAIL timeout_state: wr_rise=%0d busy=%b tout=%0d required 0/0/1", wr_rise, bif.busy, tout_cnt);
        end
    endtask

    task automatic test_long_rx();
        do_read(8'h12, 8'h5A, 2, 10, 1'b0);
        repeat (20) @(posedge clk); #1;
        checks++;
        if (rd_rise != 1 || txen_cnt != 1 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL long_rx: rd_rise=%0d tx_en=%0d busy=%b required 1/1/0", rd_rise, txen_cnt, bif.busy);
        end
    endtask

    task automatic test_reset_mid();
        int t0, n;
        @(posedge clk); #1 clear_mon();
        send_byte(8'h33, 1, t0);
        n = 0;
        while (bif.bus_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bif.bus_rd !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: bus_rd=%b busy=%b required 0/0", bif.bus_rd, bif.busy);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (txen_cnt != 0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_tx: tx_en=%0d busy=%b required 0/0", txen_cnt, bif.busy);
        end
        do_write(8'h85, 8'h01, 1);
    endtask

    task automatic test_random();
        logic [7:0] hdr, data;
        for (int i = 0; i < 16; i++) begin
            hdr  = 8'($urandom_range(0, 255));
            data = 8'($urandom);
            if (hdr >= 8'd128) do_write(hdr, data, $urandom_range(0, 4));
            else do_read(hdr, data, $urandom_range(0, 4), $urandom_range(1, 3), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_stray();
        do_write(8'h85, 8'h3C, 3);
        do_read(8'h12, 8'hA7, 1, 1, 1'b0);
        test_timeout();
        do_read(8'h21, 8'hC3, 0, 1, 1'b1);
        test_long_rx();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
